// File: rtl/ecdsa_dma_sequencer.sv
// Multi-word DMA sequencer: walks cmd_count 381-bit words between DDR (128-byte stride) and the
// operand/result banks one interfacer beat at a time. Optional watchdog: ECDSA_DMA_TIMEOUT_EN.
module ecdsa_dma_sequencer #(
   parameter int DATA_W      = 381,
   parameter int MAX_OPS     = 8,
   parameter int IDX_W       = 3,
   parameter int TIMEOUT_CYC = 4096
) (
   input  logic              aclk,
   input  logic              aresetn,
   input  logic              cmd_start,
   input  logic              cmd_dir,
   input  logic [31:0]       cmd_base_addr,
   input  logic [IDX_W:0]    cmd_count,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic              dma_c2f_start,
   output logic [31:0]       dma_c2f_addr,
   input  logic [DATA_W-1:0] dma_c2f_data,
   output logic              dma_f2c_start,
   output logic [31:0]       dma_f2c_addr,
   output logic [DATA_W-1:0] dma_f2c_data,
   input  logic              dma_done,
   input  logic              dma_idle,
   input  logic              dma_error,
   output logic              op_wr_en,
   output logic [IDX_W-1:0]  op_wr_idx,
   output logic [DATA_W-1:0] op_wr_data,
   output logic [IDX_W-1:0]  res_rd_idx,
   input  logic [DATA_W-1:0] res_rd_data
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_FIN   = 2'd3;

   localparam logic [IDX_W:0]   MAX_CNT = MAX_OPS[IDX_W:0];
   localparam logic [IDX_W:0]   CNT_ONE = {{IDX_W{1'b0}}, 1'b1};
   localparam logic [IDX_W-1:0] IDX_ONE = {{(IDX_W-1){1'b0}}, 1'b1};
   localparam logic [31:0]      STRIDE  = 32'd128;

   logic [1:0]        state_q, state_d;
   logic              dir_q, dir_d;
   logic [31:0]       addr_q, addr_d;
   logic [IDX_W:0]    cnt_q, cnt_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic              err_q, err_d;
   logic              done_q, done_d;
   logic              busy_q, busy_d;
   logic [DATA_W-1:0] f2c_data_q, f2c_data_d;
   logic              op_wr_en_q, op_wr_en_d;
   logic [IDX_W-1:0]  op_wr_idx_q, op_wr_idx_d;
   logic [DATA_W-1:0] op_wr_data_q, op_wr_data_d;

   logic cmd_bad;
   logic last_beat;
   logic issue_go;
   logic timeout;

   assign cmd_bad   = (cmd_count == '0) || (cmd_count > MAX_CNT) || (cmd_base_addr[6:0] != 7'd0);
   assign last_beat = ({1'b0, idx_q} == (cnt_q - CNT_ONE));
   // Starts are combinational so they can never be seen with a stale dma_idle.
   assign issue_go  = (state_q == S_ISSUE) && dma_idle && !dma_error;

`ifdef ECDSA_DMA_TIMEOUT_EN
   localparam logic [15:0] WD_LIMIT = 16'(TIMEOUT_CYC - 1);
   logic [15:0] wd_q, wd_d;

   // Restarts at every ISSUE, so the limit applies per beat.
   assign timeout = (state_q == S_WAIT) && !dma_done && (wd_q == WD_LIMIT);

   always_comb begin
      wd_d = 16'd0;
      if (state_q == S_WAIT) wd_d = wd_q + 16'd1;
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) wd_q <= 16'd0;
      else          wd_q <= wd_d;
   end
`else
   logic unused_tmo;
   assign unused_tmo = ^TIMEOUT_CYC;
   assign timeout    = 1'b0;
`endif

   always_comb begin
      state_d      = state_q;
      dir_d        = dir_q;
      addr_d       = addr_q;
      cnt_d        = cnt_q;
      idx_d        = idx_q;
      err_d        = err_q;
      done_d       = 1'b0;
      busy_d       = busy_q;
      f2c_data_d   = f2c_data_q;
      op_wr_en_d   = 1'b0;
      op_wr_idx_d  = op_wr_idx_q;
      op_wr_data_d = op_wr_data_q;
      case (state_q)
         S_IDLE: begin
            if (cmd_start) begin
               if (cmd_bad) begin
                  err_d  = 1'b1;
                  done_d = 1'b1;
               end else begin
                  dir_d   = cmd_dir;
                  addr_d  = cmd_base_addr;
                  cnt_d   = cmd_count;
                  idx_d   = '0;
                  err_d   = 1'b0;
                  busy_d  = 1'b1;
                  state_d = S_ISSUE;
               end
            end
         end
         S_ISSUE: begin
            if (dma_error) begin
               err_d   = 1'b1;
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = S_FIN;
            end else if (dma_idle) begin
               if (dir_q) f2c_data_d = res_rd_data;
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            // The bank write for a completed beat lands even if dma_error arrives with it.
            if (dma_done && !dir_q) begin
               op_wr_en_d   = 1'b1;
               op_wr_idx_d  = idx_q;
               op_wr_data_d = dma_c2f_data;
            end
            if (dma_error || timeout) begin
               err_d   = 1'b1;
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = S_FIN;
            end else if (dma_done) begin
               if (last_beat) begin
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
                  state_d = S_FIN;
               end else begin
                  idx_d   = idx_q + IDX_ONE;
                  addr_d  = addr_q + STRIDE;
                  state_d = S_ISSUE;
               end
            end
         end
         S_FIN:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state_q      <= S_IDLE;
         dir_q        <= 1'b0;
         addr_q       <= '0;
         cnt_q        <= '0;
         idx_q        <= '0;
         err_q        <= 1'b0;
         done_q       <= 1'b0;
         busy_q       <= 1'b0;
         f2c_data_q   <= '0;
         op_wr_en_q   <= 1'b0;
         op_wr_idx_q  <= '0;
         op_wr_data_q <= '0;
      end else begin
         state_q      <= state_d;
         dir_q        <= dir_d;
         addr_q       <= addr_d;
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         err_q        <= err_d;
         done_q       <= done_d;
         busy_q       <= busy_d;
         f2c_data_q   <= f2c_data_d;
         op_wr_en_q   <= op_wr_en_d;
         op_wr_idx_q  <= op_wr_idx_d;
         op_wr_data_q <= op_wr_data_d;
      end
   end

   assign busy          = busy_q;
   assign done          = done_q;
   assign err           = err_q;
   assign dma_c2f_start = issue_go && !dir_q;
   assign dma_f2c_start = issue_go && dir_q;
   assign dma_c2f_addr  = addr_q;
   assign dma_f2c_addr  = addr_q;
   assign dma_f2c_data  = f2c_data_q;
   assign op_wr_en      = op_wr_en_q;
   assign op_wr_idx     = op_wr_idx_q;
   assign op_wr_data    = op_wr_data_q;
   assign res_rd_idx    = idx_q;

endmodule

// File: tb/tb_ecdsa_dma_sequencer.sv
// Scoreboard bench for ecdsa_dma_sequencer: interfacer model on negedges, expectations queued
// by the stimulus, monitor pops and compares on every DUT event.
module tb_ecdsa_dma_sequencer;
   localparam int DW  = 381;
   localparam int IW  = 3;
   localparam int TMO = 4096;

   logic          aclk, aresetn;
   logic          cmd_start, cmd_dir;
   logic [31:0]   cmd_base_addr;
   logic [IW:0]   cmd_count;
   logic          busy, done, err;
   logic          dma_c2f_start, dma_f2c_start;
   logic [31:0]   dma_c2f_addr, dma_f2c_addr;
   logic [DW-1:0] dma_c2f_data, dma_f2c_data, op_wr_data, res_rd_data;
   logic          dma_done, dma_idle, dma_error, op_wr_en;
   logic [IW-1:0] op_wr_idx, res_rd_idx;
   logic [DW-1:0] res_bank [0:7];

   assign res_rd_data = res_bank[res_rd_idx];

   ecdsa_dma_sequencer #(.DATA_W(DW), .MAX_OPS(8), .IDX_W(IW), .TIMEOUT_CYC(TMO)) dut (
      .aclk(aclk), .aresetn(aresetn), .cmd_start(cmd_start), .cmd_dir(cmd_dir),
      .cmd_base_addr(cmd_base_addr), .cmd_count(cmd_count), .busy(busy), .done(done), .err(err),
      .dma_c2f_start(dma_c2f_start), .dma_c2f_addr(dma_c2f_addr), .dma_c2f_data(dma_c2f_data),
      .dma_f2c_start(dma_f2c_start), .dma_f2c_addr(dma_f2c_addr), .dma_f2c_data(dma_f2c_data),
      .dma_done(dma_done), .dma_idle(dma_idle), .dma_error(dma_error),
      .op_wr_en(op_wr_en), .op_wr_idx(op_wr_idx), .op_wr_data(op_wr_data),
      .res_rd_idx(res_rd_idx), .res_rd_data(res_rd_data));

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   typedef struct packed { logic [IW-1:0] idx; logic [DW-1:0] data; } opw_t;
   typedef struct packed { logic [31:0] addr; logic [DW-1:0] data; } wr_t;

   opw_t        q_opw [$];
   logic [31:0] q_rd  [$];
   wr_t         q_wr  [$];
   logic        q_done[$];

   int checks, errors;
   int stall, err_beat, beat_no;
   bit hold_done;

   function automatic logic [DW-1:0] mem_word(input logic [31:0] a);
      logic [383:0] t;
      t = {~a, {10{a ^ 32'h5A5A_C3C3}}, a};
      return t[DW-1:0];
   endfunction

   task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic unexp(input string nm);
      checks++;
      errors++;
      $display("FAIL %s: event seen, none expected", nm);
   endtask

   // Interfacer model: one beat per start, done after `stall` extra cycles.
   initial begin : bus
      int st, left;
      bit rd;
      logic [31:0] a;
      st = 0; left = 0; rd = 0; a = '0;
      dma_idle = 1'b1; dma_done = 1'b0; dma_error = 1'b0; dma_c2f_data = '0;
      forever begin
         @(negedge aclk);
         if (!aresetn) begin
            st = 0; dma_idle = 1'b1; dma_done = 1'b0;
         end else begin
            case (st)
               1: begin
                  dma_idle = 1'b0;
                  if (!hold_done && left == 0) begin
                     dma_done = 1'b1;
                     beat_no++;
                     if (rd) dma_c2f_data = mem_word(a);
                     if (beat_no == err_beat) dma_error = 1'b1;
                     st = 2;
                  end else if (left > 0) left--;
               end
               2: begin dma_done = 1'b0; dma_idle = 1'b1; st = 0; end
               default: ;
            endcase
         end
         #1;
         if (st == 0 && aresetn && (dma_c2f_start || dma_f2c_start)) begin
            rd = dma_c2f_start;
            a = rd ? dma_c2f_addr : dma_f2c_addr;
            left = stall;
            st = 1;
         end
      end
   end

   initial begin : mon
      logic [DW-1:0] pend;
      bit pend_v;
      pend = '0; pend_v = 0;
      forever begin
         @(negedge aclk);
         #2;
         if (!aresetn) pend_v = 0;
         else begin
            if (op_wr_en) begin
               if (q_opw.size() == 0) unexp("op_wr");
               else begin
                  opw_t e;
                  e = q_opw.pop_front();
                  chk("op_wr_idx", DW'(op_wr_idx), DW'(e.idx));
                  chk("op_wr_data", op_wr_data, e.data);
               end
            end
            if (dma_c2f_start || dma_f2c_start) begin
               chk("start_while_idle", DW'(dma_idle), DW'(1));
               chk("start_exclusive", DW'(dma_c2f_start & dma_f2c_start), DW'(0));
            end
            if (dma_c2f_start) begin
               if (q_rd.size() == 0) unexp("c2f_start");
               else chk("c2f_addr", DW'(dma_c2f_addr), DW'(q_rd.pop_front()));
            end
            if (dma_f2c_start) begin
               if (q_wr.size() == 0) unexp("f2c_start");
               else begin
                  wr_t w;
                  w = q_wr.pop_front();
                  chk("f2c_addr", DW'(dma_f2c_addr), DW'(w.addr));
                  pend = w.data;
                  pend_v = 1;
               end
            end
            if (dma_done && pend_v) begin
               chk("f2c_data", dma_f2c_data, pend);
               pend_v = 0;
            end
            if (done) begin
               if (q_done.size() == 0) unexp("done");
               else begin
                  logic e;
                  e = q_done.pop_front();
                  chk("done_err", DW'(err), DW'(e));
                  chk("done_busy", DW'(busy), DW'(0));
               end
            end
         end
      end
   end

   task automatic exp_load(input logic [31:0] base, input int n);
      for (int i = 0; i < n; i++) begin
         opw_t o;
         q_rd.push_back(base + 32'(i * 128));
         o.idx  = IW'(i);
         o.data = mem_word(base + 32'(i * 128));
         q_opw.push_back(o);
      end
   endtask

   task automatic run_cmd(input logic dir, input logic [31:0] base, input logic [IW:0] cnt,
                          input int lim, output int lat);
      @(negedge aclk);
      cmd_start = 1'b1; cmd_dir = dir; cmd_base_addr = base; cmd_count = cnt;
      @(negedge aclk);
      cmd_start = 1'b0;
      lat = 1;
      while (!done && lat < lim) begin
         @(negedge aclk);
         lat++;
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL cmd_done_timeout: no done after %0d cycles", lat);
      end
      @(negedge aclk);
   endtask

   initial begin : main
      int lat, seen;
      wr_t w;
      checks = 0; errors = 0; stall = 0; err_beat = 0; beat_no = 0; hold_done = 0;
      cmd_start = 1'b0; cmd_dir = 1'b0; cmd_base_addr = '0; cmd_count = '0;
      for (int i = 0; i < 8; i++) res_bank[i] = mem_word(32'hC0DE_0000 + 32'(i));
      aresetn = 1'b0;
      repeat (3) @(negedge aclk);
      chk("rst_busy", DW'(busy), DW'(0));
      chk("rst_done", DW'(done), DW'(0));
      chk("rst_err", DW'(err), DW'(0));
      chk("rst_starts", DW'({dma_c2f_start, dma_f2c_start, op_wr_en}), DW'(0));
      chk("rst_addr", DW'({dma_c2f_addr, dma_f2c_addr, op_wr_idx, res_rd_idx}), DW'(0));
      chk("rst_opdata", op_wr_data, '0);
      chk("rst_f2cdata", dma_f2c_data, '0);
      aresetn = 1'b1;

      // 1: three-word LOAD
      exp_load(32'h1000_0000, 3);
      q_done.push_back(1'b0);
      run_cmd(1'b0, 32'h1000_0000, 4'd3, 200, lat);
      chk("t1_err", DW'(err), DW'(0));

      // 2: two-word STORE with 5-cycle stalls
      stall = 5;
      res_bank[0] = mem_word(32'hDEAD_BEEF);
      res_bank[1] = mem_word(32'h0BAD_F00D);
      w.addr = 32'h2000_0000; w.data = mem_word(32'hDEAD_BEEF); q_wr.push_back(w);
      w.addr = 32'h2000_0080; w.data = mem_word(32'h0BAD_F00D); q_wr.push_back(w);
      q_done.push_back(1'b0);
      run_cmd(1'b1, 32'h2000_0000, 4'd2, 200, lat);
      chk("t2_busy", DW'(busy), DW'(0));

      // 3: illegal commands, then a legal one clears err
      stall = 0;
      q_done.push_back(1'b1);
      run_cmd(1'b0, 32'h1000_0040, 4'd1, 50, lat);
      chk("t3_misalign_lat", DW'(lat), DW'(1));
      chk("t3_misalign_err", DW'(err), DW'(1));
      q_done.push_back(1'b1);
      run_cmd(1'b0, 32'h1000_0000, 4'd0, 50, lat);
      chk("t3_cnt0_lat", DW'(lat), DW'(1));
      q_done.push_back(1'b1);
      run_cmd(1'b1, 32'h1000_0000, 4'd9, 50, lat);
      chk("t3_cnt9_lat", DW'(lat), DW'(1));
      chk("t3_cnt9_err", DW'(err), DW'(1));
      exp_load(32'h3000_0000, 1);
      q_done.push_back(1'b0);
      run_cmd(1'b0, 32'h3000_0000, 4'd1, 100, lat);
      chk("t3_err_cleared", DW'(err), DW'(0));

      // 4: dma_error together with beat 2 done of a 4-word LOAD
      beat_no = 0; err_beat = 2;
      exp_load(32'h4000_0000, 2);
      q_done.push_back(1'b1);
      run_cmd(1'b0, 32'h4000_0000, 4'd4, 200, lat);
      chk("t4_err", DW'(err), DW'(1));
      chk("t4_busy", DW'(busy), DW'(0));
      dma_error = 1'b0; err_beat = 0;

      // 5: reset in the middle of WAIT
      stall = 10;
      q_rd.push_back(32'h5000_0000);
      @(negedge aclk);
      cmd_start = 1'b1; cmd_dir = 1'b0; cmd_base_addr = 32'h5000_0000; cmd_count = 4'd2;
      @(negedge aclk);
      cmd_start = 1'b0;
      repeat (3) @(negedge aclk);
      chk("t5_busy_pre", DW'(busy), DW'(1));
      aresetn = 1'b0;
      @(negedge aclk);
      chk("t5_rst_flags", DW'({busy, done, err, dma_c2f_start, dma_f2c_start, op_wr_en}), DW'(0));
      chk("t5_rst_addr", DW'({dma_c2f_addr, dma_f2c_addr, op_wr_idx, res_rd_idx}), DW'(0));
      chk("t5_rst_opdata", op_wr_data, '0);
      @(negedge aclk);
      aresetn = 1'b1;
      q_rd.delete(); q_opw.delete(); q_done.delete();
      seen = 0;
      repeat (20) begin
         @(negedge aclk);
         if (done) seen++;
      end
      chk("t5_no_done", DW'(seen), DW'(0));
      stall = 0;
      exp_load(32'h5000_0000, 1);
      q_done.push_back(1'b0);
      run_cmd(1'b0, 32'h5000_0000, 4'd1, 100, lat);
      chk("t5_fresh_err", DW'(err), DW'(0));

`ifdef ECDSA_DMA_TIMEOUT_EN
      // 6: watchdog expiry, late done afterwards must be ignored
      hold_done = 1;
      q_rd.push_back(32'h6000_0000);
      q_done.push_back(1'b1);
      run_cmd(1'b0, 32'h6000_0000, 4'd1, TMO + 100, lat);
      chk("t6_lat", DW'(lat), DW'(TMO + 2));
      chk("t6_err", DW'(err), DW'(1));
      hold_done = 0;
      repeat (6) @(negedge aclk);
      chk("t6_busy", DW'(busy), DW'(0));
`endif

      repeat (4) @(negedge aclk);
      chk("q_rd_empty", DW'(q_rd.size()), DW'(0));
      chk("q_wr_empty", DW'(q_wr.size()), DW'(0));
      chk("q_opw_empty", DW'(q_opw.size()), DW'(0));
      chk("q_done_empty", DW'(q_done.size()), DW'(0));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin : guard
      #600000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "stopping");
   end

endmodule
